dco_nco_ramp: RTL and testbench

//   Parametrised successor to the single-channel DCO. Phase-accumulator NCO clocked by sys_clk.

---
 rtl/dco_nco_ramp_pkg.sv | 17 +
 rtl/dco_nco_ramp_if.sv | 28 ++
 rtl/dco_nco_ramp_lfsr16.sv | 32 +++
 rtl/dco_nco_ramp.sv | 129 ++++++++++++
 tb/tb_dco_nco_ramp.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dco_nco_ramp_pkg.sv
// Shared definitions for the ramped NCO: FSM state encoding, dither LFSR constants
// and default widths.
package dco_pkg;

  localparam int unsigned DCO_WIDTH_DEF      = 32;
  localparam int unsigned DCO_PHASE_BITS_DEF = 8;

  typedef enum logic {
    DCO_HOLD = 1'b0,
    DCO_RAMP = 1'b1
  } dco_state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] DCO_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DCO_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dco_nco_ramp_if.sv
// Control/tuning and output bundle of the ramped NCO.
// The master drives tuning and control; the slave is the NCO itself.
interface dco_nco_ramp_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PHASE_BITS = 8
);
  logic                  en;
  logic                  sync_clr;
  logic                  tw_valid;
  logic                  tw_ready;
  logic [WIDTH-1:0]      tw_data;
  logic [WIDTH-1:0]      phase_offset;
  logic [WIDTH-1:0]      freq_now;
  logic                  ramp_busy;
  logic                  dco_out;
  logic [PHASE_BITS-1:0] phase_out;
  logic                  wrap_pulse;

  modport master (
    output en, sync_clr, tw_valid, tw_data, phase_offset,
    input  tw_ready, freq_now, ramp_busy, dco_out, phase_out, wrap_pulse
  );

  modport slave (
    input  en, sync_clr, tw_valid, tw_data, phase_offset,
    output tw_ready, freq_now, ramp_busy, dco_out, phase_out, wrap_pulse
  );
endinterface

// File: rtl/dco_nco_ramp_lfsr16.sv
// 16-bit maximal LFSR used to dither the phase decode; built only when DCO_DITHER_EN
// is defined, advancing once per enabled cycle.
`ifdef DCO_DITHER_EN
module dco_lfsr16
  import dco_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state_o
);
  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? DCO_LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DCO_LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule
`endif

// File: rtl/dco_nco_ramp.sv
// Phase-accumulator NCO with valid/ready tuning load and slew-limited frequency ramp.
// Define DCO_DITHER_EN to add LFSR dither to the phase decode.
module dco_nco_ramp
  import dco_pkg::*;
#(
  parameter int unsigned WIDTH      = DCO_WIDTH_DEF,
  parameter int unsigned PHASE_BITS = DCO_PHASE_BITS_DEF,
  parameter int unsigned SLEW_STEP  = 0
) (
  input logic          sys_clk,
  input logic          rst_n,
  dco_nco_ramp_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(SLEW_STEP);

  dco_state_e            state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      freq_q, freq_d;
  logic [WIDTH-1:0]      target_q, target_d;
  logic                  wrap_q, wrap_d;
  logic                  dco_q;
  logic [PHASE_BITS-1:0] phase_q;
  logic [WIDTH-1:0]      diff_up, diff_dn;
  logic [WIDTH:0]        acc_sum;
  logic [WIDTH-1:0]      dith;
  logic [WIDTH-1:0]      p;

  // Ramp FSM: HOLD accepts words; RAMP walks freq toward target by at most STEP
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    target_d = target_q;
    diff_up  = target_q - freq_q;
    diff_dn  = freq_q - target_q;
    case (state_q)
      DCO_HOLD: begin
        if (bus.tw_valid) begin
          target_d = bus.tw_data;
          if (SLEW_STEP == 0) begin
            freq_d = bus.tw_data;
          end else if (bus.tw_data != freq_q) begin
            state_d = DCO_RAMP;
          end
        end
      end
      DCO_RAMP: begin
        if (target_q >= freq_q) begin
          if (diff_up <= STEP) begin
            freq_d  = target_q;
            state_d = DCO_HOLD;
          end else begin
            freq_d = freq_q + STEP;
          end
        end else begin
          if (diff_dn <= STEP) begin
            freq_d  = target_q;
            state_d = DCO_HOLD;
          end else begin
            freq_d = freq_q - STEP;
          end
        end
      end
    endcase
  end

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, freq_q};
    acc_d   = acc_q;
    wrap_d  = 1'b0;
    if (bus.sync_clr) begin
      acc_d = '0;
    end else if (bus.en) begin
      acc_d  = acc_sum[WIDTH-1:0];
      wrap_d = acc_sum[WIDTH];
    end
  end

`ifdef DCO_DITHER_EN
  localparam int unsigned DITH_BITS = ((WIDTH - PHASE_BITS) < 16) ? (WIDTH - PHASE_BITS) : 16;
  logic [15:0] lfsr;

  dco_lfsr16 u_lfsr (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .state_o (lfsr)
  );

  if (DITH_BITS > 0) begin : g_dith
    assign dith = WIDTH'(lfsr[DITH_BITS-1:0]);
  end else begin : g_no_dith
    assign dith = '0;
  end
`else
  assign dith = '0;
`endif

  assign p = acc_q + bus.phase_offset + dith;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DCO_HOLD;
      acc_q    <= '0;
      freq_q   <= '0;
      target_q <= '0;
      wrap_q   <= 1'b0;
      dco_q    <= 1'b0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      target_q <= target_d;
      wrap_q   <= wrap_d;
      // decode freezes with the accumulator, but a sync clear still refreshes it
      if (bus.en || bus.sync_clr) begin
        dco_q   <= p[WIDTH-1];
        phase_q <= p[WIDTH-1 -: PHASE_BITS];
      end
    end
  end

  assign bus.tw_ready   = (state_q == DCO_HOLD);
  assign bus.ramp_busy  = (state_q == DCO_RAMP);
  assign bus.freq_now   = freq_q;
  assign bus.dco_out    = dco_q;
  assign bus.phase_out  = phase_q;
  assign bus.wrap_pulse = wrap_q;
endmodule

// File: tb/tb_dco_nco_ramp.sv
// Directed bench: dut0 (immediate jump) runs a vector table plus period checks,
// dut1 (SLEW_STEP=2^20) runs ramp, sync-clear, freeze and async-reset sequences.
module tb_dco_nco_ramp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  dco_nco_ramp_if #(.WIDTH(32), .PHASE_BITS(8)) if0 ();
  dco_nco_ramp_if #(.WIDTH(32), .PHASE_BITS(8)) if1 ();

  dco_nco_ramp #(.WIDTH(32), .PHASE_BITS(8), .SLEW_STEP(0)) dut0 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (if0)
  );

  dco_nco_ramp #(.WIDTH(32), .PHASE_BITS(8), .SLEW_STEP(1048576)) dut1 (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (if1)
  );

  typedef struct {
    logic        en;
    logic        sync_clr;
    logic        tw_valid;
    logic [31:0] tw_data;
    logic [31:0] phase_offset;
    logic [31:0] exp_freq;
    logic        exp_dco;
    logic [7:0]  exp_phase;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return if0.dco_out;
      1:       return if1.dco_out;
      default: return if0.wrap_pulse;
    endcase
  endfunction

  // Distance in cycles between two successive rising edges of the selected signal
  task automatic measure_period(input int sel, input int exp, input string name);
    logic prev, cur;
    bit   found;
    int   cnt;
    found = 0;
    prev  = get_sig(sel);
    cur   = prev;
    for (int i = 0; i < 400; i++) begin
      tick();
      cur = get_sig(sel);
      if (cur && !prev) begin
        found = 1;
        break;
      end
      prev = cur;
    end
    check({name, "_first_edge"}, 64'(found), 64'd1);
    cnt   = 0;
    found = 0;
    prev  = cur;
    for (int i = 0; i < 400; i++) begin
      tick();
      cnt++;
      cur = get_sig(sel);
      if (cur && !prev) begin
        found = 1;
        break;
      end
      prev = cur;
    end
    check({name, "_second_edge"}, 64'(found), 64'd1);
    check_range(name, cnt, exp - 1, exp + 1);
    $display("%s: period %0d cycles", name, cnt);
  endtask

  // Load a word into dut1 and follow the ramp; optionally start offering next_word mid-ramp
  task automatic ramp_run(input logic [31:0] word, input bit preload,
                          input logic [31:0] next_word, input string name);
    logic [31:0] prev, start;
    int          cnt;
    bit          up, ok_mono;
    start = if1.freq_now;
    up    = (word > start);
    check({name, "_ready_before"}, 64'(if1.tw_ready), 64'd1);
    if1.tw_valid = 1'b1;
    if1.tw_data  = word;
    tick();
    if1.tw_valid = 1'b0;
    check({name, "_busy"}, 64'(if1.ramp_busy), 64'd1);
    check({name, "_freq_on_accept"}, 64'(if1.freq_now), 64'(start));
    prev    = start;
    cnt     = 0;
    ok_mono = 1;
    while (if1.tw_ready == 1'b0 && cnt < 200) begin
      if (preload && cnt >= 10) begin
        if1.tw_valid = 1'b1;
        if1.tw_data  = next_word;
      end
      tick();
      cnt++;
      if (up ? (if1.freq_now <= prev) : (if1.freq_now >= prev)) ok_mono = 0;
      prev = if1.freq_now;
    end
    check({name, "_monotonic"}, 64'(ok_mono), 64'd1);
    check({name, "_busy_cycles"}, 64'(cnt), 64'd41);
    check({name, "_final_freq"}, 64'(if1.freq_now), 64'(word));
    check({name, "_busy_done"}, 64'(if1.ramp_busy), 64'd0);
    $display("%s: ramp %0d -> %0d took %0d cycles", name, start, if1.freq_now, cnt);
  endtask

  initial begin
    logic       frozen_ok, no_wrap;
    logic       dco_hold;
    logic [7:0] ph_hold;

    if0.en = 0; if0.sync_clr = 0; if0.tw_valid = 0; if0.tw_data = 0; if0.phase_offset = 0;
    if1.en = 0; if1.sync_clr = 0; if1.tw_valid = 0; if1.tw_data = 0; if1.phase_offset = 0;

    //          en sc  v  data          offset        freq          dco ph     wrap
    vecs[0]  = '{1, 0, 1, 32'h40000000, 32'h0,        32'h40000000, 0, 8'h00, 0};
    vecs[1]  = '{1, 0, 0, 32'h0,        32'h0,        32'h40000000, 0, 8'h00, 0};
    vecs[2]  = '{1, 0, 0, 32'h0,        32'h0,        32'h40000000, 0, 8'h40, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,        32'h0,        32'h40000000, 1, 8'h80, 0};
    vecs[4]  = '{1, 0, 0, 32'h0,        32'h0,        32'h40000000, 1, 8'hC0, 1};
    vecs[5]  = '{1, 0, 0, 32'h0,        32'h0,        32'h40000000, 0, 8'h00, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,        32'h0,        32'h40000000, 0, 8'h00, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,        32'h12345678, 32'h40000000, 0, 8'h00, 0};
    vecs[8]  = '{1, 0, 0, 32'h0,        32'h12345678, 32'h40000000, 0, 8'h52, 0};
    vecs[9]  = '{1, 1, 0, 32'h0,        32'h12345678, 32'h40000000, 1, 8'h92, 0};
    vecs[10] = '{1, 0, 0, 32'h0,        32'h12345678, 32'h40000000, 0, 8'h12, 0};
    vecs[11] = '{1, 0, 1, 32'hC0000000, 32'h0,        32'hC0000000, 0, 8'h40, 0};
    vecs[12] = '{1, 0, 0, 32'h0,        32'h0,        32'hC0000000, 1, 8'h80, 1};
    vecs[13] = '{0, 1, 0, 32'h0,        32'h0,        32'hC0000000, 0, 8'h40, 0};
    vecs[14] = '{0, 0, 0, 32'h0,        32'h0,        32'hC0000000, 0, 8'h40, 0};
    vecs[15] = '{1, 0, 1, 32'h0,        32'h0,        32'h00000000, 0, 8'h00, 0};
    vecs[16] = '{1, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, 8'hC0, 0};
    vecs[17] = '{1, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, 8'hC0, 0};

    #2;
    check("rst_ready0", 64'(if0.tw_ready), 64'd1);
    check("rst_busy1",  64'(if1.ramp_busy), 64'd0);
    check("rst_freq1",  64'(if1.freq_now), 64'd0);
    check("rst_phase0", 64'(if0.phase_out), 64'd0);
    check("rst_dco0",   64'(if0.dco_out), 64'd0);
    check("rst_wrap0",  64'(if0.wrap_pulse), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      if0.en           = vecs[i].en;
      if0.sync_clr     = vecs[i].sync_clr;
      if0.tw_valid     = vecs[i].tw_valid;
      if0.tw_data      = vecs[i].tw_data;
      if0.phase_offset = vecs[i].phase_offset;
      tick();
      check($sformatf("vec%0d_freq", i),  64'(if0.freq_now),   64'(vecs[i].exp_freq));
      check($sformatf("vec%0d_dco", i),   64'(if0.dco_out),    64'(vecs[i].exp_dco));
      check($sformatf("vec%0d_phase", i), 64'(if0.phase_out),  64'(vecs[i].exp_phase));
      check($sformatf("vec%0d_wrap", i),  64'(if0.wrap_pulse), 64'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_ready", i), 64'(if0.tw_ready),   64'd1);
      $display("vec %0d: en=%0b clr=%0b freq=%08h dco=%0b phase=%02h wrap=%0b",
               i, vecs[i].en, vecs[i].sync_clr, if0.freq_now, if0.dco_out,
               if0.phase_out, if0.wrap_pulse);
    end
    if0.tw_valid = 0;
    if0.sync_clr = 0;

    // immediate jump: word applied on the accepting edge
    if0.en       = 1;
    if0.tw_valid = 1;
    if0.tw_data  = 32'd42949673;
    tick();
    if0.tw_valid = 0;
    check("t1_freq_next_cycle", 64'(if0.freq_now), 64'd42949673);
    measure_period(0, 100, "t1_dco_period");
    measure_period(2, 100, "t1_wrap_period");

    // up-ramp with a word offered while busy, then held until accepted
    if1.en = 1;
    ramp_run(32'd42949673, 1'b1, 32'd85899346, "t2_up");
    ramp_run(32'd85899346, 1'b0, 32'd0,        "t3_up");
    measure_period(1, 50, "t3_dco_period");
    ramp_run(32'd42949673, 1'b0, 32'd0,        "t4_down");

    // sync clear then freeze
    if1.phase_offset = 32'h5A000000;
    tick();
    if1.sync_clr = 1;
    tick();
    if1.sync_clr = 0;
    check("t5_wrap_after_clr", 64'(if1.wrap_pulse), 64'd0);
    tick();
    check("t5_phase_is_offset", 64'(if1.phase_out), 64'h5A);
    check("t5_dco_is_offset",   64'(if1.dco_out),   64'd0);
    tick();
    if1.en    = 0;
    tick();
    dco_hold  = if1.dco_out;
    ph_hold   = if1.phase_out;
    frozen_ok = 1;
    no_wrap   = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.dco_out !== dco_hold || if1.phase_out !== ph_hold) frozen_ok = 0;
      if (if1.wrap_pulse !== 1'b0) no_wrap = 0;
    end
    check("t5_frozen", 64'(frozen_ok), 64'd1);
    check("t5_no_wrap", 64'(no_wrap), 64'd1);
    $display("t5: frozen phase=%02h dco=%0b", ph_hold, dco_hold);
    if1.en = 1;

    // async reset mid-ramp
    if1.tw_valid = 1;
    if1.tw_data  = 32'd85899346;
    tick();
    if1.tw_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t6_busy_before_rst", 64'(if1.ramp_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ready",  64'(if1.tw_ready),   64'd1);
    check("t6_busy",   64'(if1.ramp_busy),  64'd0);
    check("t6_freq",   64'(if1.freq_now),   64'd0);
    check("t6_dco",    64'(if1.dco_out),    64'd0);
    check("t6_phase",  64'(if1.phase_out),  64'd0);
    check("t6_wrap",   64'(if0.wrap_pulse), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_target_discarded", 64'(if1.freq_now), 64'd0);
    check("t6_stays_hold",       64'(if1.tw_ready), 64'd1);
    $display("t6: post-reset freq=%0d ready=%0b", if1.freq_now, if1.tw_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
